board_mem_arbiter: RTL and testbench

- Shares one single-port synchronous board-state RAM between three requesters: the grid draw pipeline (read-only, absolute priority) and two game-side requesters, A (local player / mouse placement) and B (remote player updates).
- Grid: 10x10 cells, 2-bit state per cell (0 empty, 1 ship, 2 hit, 3 miss).
- Sits in the 65 MHz VGA domain (1024x768, 1344x806 total) between the game logic and the draw_grid renderer.
- Gives the renderer fixed-latency reads and A/B round-robin access with valid/ready handshakes.

---
 rtl/board_mem_arbiter.sv | 108 ++++++++++
 tb/tb_board_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares one single-port board-state RAM between the grid renderer and requesters A/B
// Optional feature macro: BOARD_ARB_VBLANK_WR_EN (A/B writes granted only during vblank)
// Ports:
//   vga_clk, rst_n          65 MHz pixel clock, async active-low reset
//   vblank                  vertical blanking flag (only used with BOARD_ARB_VBLANK_WR_EN)
//   draw_rd_en/draw_addr    renderer read, absolute priority; draw_rd_data/draw_rd_valid two cycles later
//   a_*/b_*                 valid/ready requesters, round-robin between them; *_rdata/*_rvalid two cycles after accept
//   mem_*                   single-port RAM interface, mem_rdata valid one cycle after a read enable
module board_mem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 2,
  parameter int GRID_CELLS = 100
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              draw_rd_en,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic [DATA_W-1:0] draw_rd_data,
  output logic              draw_rd_valid,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {TAG_NONE, TAG_DRAW, TAG_A, TAG_B} tag_t;
  logic              w_a_elig;
  logic              w_b_elig;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_active;
  logic              w_we;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  tag_t              w_tag;
  tag_t              r_tag;
  logic              r_oor;
  logic              r_last_b;
`ifdef BOARD_ARB_VBLANK_WR_EN
  // a write outside vblank is simply not eligible, so it never blocks the other side
  assign w_a_elig = a_valid && (!a_we || vblank);
  assign w_b_elig = b_valid && (!b_we || vblank);
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_a_elig = a_valid;
  assign w_b_elig = b_valid;
`endif
  always_comb begin
    // A wins a conflict when B was served last
    w_gnt_a    = !draw_rd_en && w_a_elig && (!w_b_elig || r_last_b);
    w_gnt_b    = !draw_rd_en && w_b_elig && !w_gnt_a;
    w_active   = draw_rd_en || w_gnt_a || w_gnt_b;
    w_addr     = draw_rd_en ? draw_addr : w_gnt_a ? a_addr : b_addr;
    w_we       = !draw_rd_en && (w_gnt_a ? a_we : (w_gnt_b && b_we));
    w_wdata    = w_gnt_a ? a_wdata : b_wdata;
    w_in_range = {1'b0, w_addr} < (ADDR_W + 1)'(GRID_CELLS);
    w_tag      = (!w_active || w_we) ? TAG_NONE : draw_rd_en ? TAG_DRAW : w_gnt_a ? TAG_A : TAG_B;
    // out-of-range reads never enable the RAM, so its stale output is masked to 0
    w_rdata    = r_oor ? '0 : mem_rdata;
  end
  assign a_ready   = w_gnt_a;
  assign b_ready   = w_gnt_b;
  assign mem_en    = w_active && w_in_range;
  assign mem_we    = mem_en && w_we;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag         <= TAG_NONE;
      r_oor         <= 1'b0;
      r_last_b      <= 1'b1;
      draw_rd_valid <= 1'b0;
      a_rvalid      <= 1'b0;
      b_rvalid      <= 1'b0;
      draw_rd_data  <= '0;
      a_rdata       <= '0;
      b_rdata       <= '0;
    end else begin
      r_tag         <= w_tag;
      r_oor         <= !w_in_range;
      if (w_gnt_a || w_gnt_b) r_last_b <= w_gnt_b;
      draw_rd_valid <= r_tag == TAG_DRAW;
      a_rvalid      <= r_tag == TAG_A;
      b_rvalid      <= r_tag == TAG_B;
      if (r_tag == TAG_DRAW) draw_rd_data <= w_rdata;
      if (r_tag == TAG_A) a_rdata <= w_rdata;
      if (r_tag == TAG_B) b_rdata <= w_rdata;
    end
  end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: randomized scoreboard bench for board_mem_arbiter against a cycle-level reference model
module tb_board_mem_arbiter;
  logic       vga_clk = 0;
  logic       rst_n, vblank, draw_rd_en;
  logic [6:0] draw_addr;
  logic [1:0] draw_rd_data;
  logic       draw_rd_valid;
  logic       a_valid, a_we, a_ready, a_rvalid;
  logic [6:0] a_addr;
  logic [1:0] a_wdata, a_rdata;
  logic       b_valid, b_we, b_ready, b_rvalid;
  logic [6:0] b_addr;
  logic [1:0] b_wdata, b_rdata;
  logic       mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [1:0] mem_wdata, mem_rdata;

  board_mem_arbiter dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .vblank(vblank),
    .draw_rd_en(draw_rd_en), .draw_addr(draw_addr), .draw_rd_data(draw_rd_data), .draw_rd_valid(draw_rd_valid),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 vga_clk = ~vga_clk;

  // write-first synchronous single-port RAM
  logic [1:0] ram [128];
  always @(posedge vga_clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model: abstract board contents plus expected responses in issue order
  typedef struct {int owner; int data; int due;} exp_t;
  exp_t q[$];
  int   model_mem [100];
  bit   m_last_b = 1;
  bit   a_e, b_e, vb_ok;
  int   g, own, addr_i, we_i, wd_i, in_r, dv, act;

  always @(negedge vga_clk) begin
    if (!rst_n) begin
      check("reset_outputs", int'({draw_rd_valid, a_rvalid, b_rvalid, draw_rd_data, a_rdata, b_rdata}), 0);
      q.delete();
      m_last_b = 1;
    end else begin
      dv = (q.size() > 0 && q[0].due == cyc) ? q[0].owner : 0;
      check("draw_rd_valid", int'(draw_rd_valid), int'(dv == 1));
      check("a_rvalid", int'(a_rvalid), int'(dv == 2));
      check("b_rvalid", int'(b_rvalid), int'(dv == 3));
      if (dv != 0) begin
        act = dv == 1 ? int'(draw_rd_data) : dv == 2 ? int'(a_rdata) : int'(b_rdata);
        check("rdata", act, q[0].data);
        void'(q.pop_front());
      end
`ifdef BOARD_ARB_VBLANK_WR_EN
      vb_ok = vblank;
`else
      vb_ok = 1;
`endif
      a_e = a_valid && (!a_we || vb_ok);
      b_e = b_valid && (!b_we || vb_ok);
      g = 0;
      if (!draw_rd_en) begin
        if (a_e && b_e) g = m_last_b ? 2 : 3;
        else if (a_e) g = 2;
        else if (b_e) g = 3;
      end
      check("a_ready", int'(a_ready), int'(g == 2));
      check("b_ready", int'(b_ready), int'(g == 3));
      if (g != 0) m_last_b = (g == 3);
      own = draw_rd_en ? 1 : g;
      addr_i = own == 1 ? int'(draw_addr) : own == 2 ? int'(a_addr) : int'(b_addr);
      we_i = own == 2 ? int'(a_we) : own == 3 ? int'(b_we) : 0;
      wd_i = own == 2 ? int'(a_wdata) : int'(b_wdata);
      in_r = int'(addr_i < 100);
      check("mem_en", int'(mem_en), int'(own != 0 && in_r == 1));
      if (own != 0 && in_r == 1) begin
        check("mem_addr", int'(mem_addr), addr_i);
        check("mem_we", int'(mem_we), we_i);
        if (we_i == 1) check("mem_wdata", int'(mem_wdata), wd_i);
      end
      if (own != 0 && we_i == 0) q.push_back('{own, in_r == 1 ? model_mem[addr_i] : 0, cyc + 2});
      if (own != 0 && we_i == 1 && in_r == 1) model_mem[addr_i] = wd_i;
    end
  end

  bit a_fire, b_fire;
  task automatic tick();
    @(negedge vga_clk);
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_fire) break;
    end
    check("a_grant_timeout", int'(a_fire), 1);
    a_valid = 0;
  endtask

  function automatic logic [6:0] pick_addr();
    int r;
    r = $urandom % 8;
    return r < 5 ? 7'($urandom % 6) : r == 5 ? 7'd99 : r == 6 ? 7'(100 + $urandom % 28) : 7'($urandom % 100);
  endfunction

  task automatic rand_step();
    draw_rd_en = ($urandom % 4) == 0;
    draw_addr  = pick_addr();
    if ($urandom % 8 == 0) vblank = !vblank;
    if (!a_valid || a_fire) begin
      a_valid = ($urandom % 3) != 0; a_we = 1'($urandom % 2); a_addr = pick_addr(); a_wdata = 2'($urandom % 4);
    end
    if (!b_valid || b_fire) begin
      b_valid = ($urandom % 3) != 0; b_we = 1'($urandom % 2); b_addr = pick_addr(); b_wdata = 2'($urandom % 4);
    end
  endtask

  task automatic idle();
    draw_rd_en = 0; a_valid = 0; b_valid = 0;
  endtask

  initial begin
    rst_n = 0; vblank = 0; draw_addr = 0;
    a_we = 0; a_addr = 0; a_wdata = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    idle();
    for (int i = 0; i < 128; i++) begin
      ram[i] = 2'($urandom % 4);
      if (i < 100) model_mem[i] = int'(ram[i]);
    end
    ram[5] = 2'd2; model_mem[5] = 2;
    repeat (3) tick();
    rst_n = 1;
    tick();
    // renderer read of cell 5
    draw_rd_en = 1; draw_addr = 5; a_valid = 1; a_we = 0; a_addr = 1;
    tick();
    draw_rd_en = 0; a_valid = 0;
    repeat (3) tick();
    // A writes 37 then reads it back
    vblank = 1;
    a_valid = 1; a_we = 1; a_addr = 37; a_wdata = 1;
    wait_a();
    a_valid = 1; a_we = 0;
    wait_a();
    repeat (3) tick();
    // A and B reads in conflict alternate
    a_valid = 1; a_we = 0; a_addr = 3; b_valid = 1; b_we = 0; b_addr = 4;
    repeat (4) tick();
    idle();
    repeat (3) tick();
    // renderer holds off A for 10 cycles
    a_valid = 1; a_we = 0; a_addr = 7;
    for (int i = 0; i < 10; i++) begin
      draw_rd_en = 1; draw_addr = 7'(i * 9);
      tick();
    end
    draw_rd_en = 0;
    wait_a();
    repeat (3) tick();
    // out-of-range read, out-of-range write, neighbour unchanged
    a_valid = 1; a_we = 0; a_addr = 120;
    wait_a();
    a_valid = 1; a_we = 1; a_addr = 100; a_wdata = 2'(model_mem[99] + 1);
    wait_a();
    a_valid = 1; a_we = 0; a_addr = 99;
    wait_a();
    repeat (3) tick();
    // B write pending outside vblank while A reads
    vblank = 0;
    b_valid = 1; b_we = 1; b_addr = 2; b_wdata = 3;
    a_valid = 1; a_we = 0; a_addr = 6;
    repeat (3) tick();
    vblank = 1;
    repeat (2) tick();
    idle();
    repeat (3) tick();
    // reset while a read is in flight
    a_valid = 1; a_we = 0; a_addr = 4;
    wait_a();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (4) tick();
    // randomized traffic
    a_fire = 1; b_fire = 1;
    repeat (2000) begin
      rand_step();
      tick();
    end
    idle();
    repeat (5) tick();
    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
